// File: rtl/gnot16_checker.sv
// Response checker for a WIDTH-bit NOT gate. Each valid a/y pair is
// checked bit-for-bit against y == ~a. The checker counts vectors and
// mismatches, captures the first failing pair, and gives a single
// pass/fail verdict once N_VEC vectors have been seen.
module gnot16_checker #(
    parameter int WIDTH = 16,
    parameter int N_VEC = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_vld,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_y,
    output logic [CNT_W-1:0] fail_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VEC - 1);

    state_t state;
    logic   mismatch;

    // Saturating increment: the error counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + 1'b1;
    endfunction

    // A response is wrong if any bit differs from the inverted stimulus.
    assign mismatch = (y != ~a);

    // Run-control FSM with registered status, counters and first-failure capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            vec_cnt  <= '0;
            err_cnt  <= '0;
            fail_vld <= 1'b0;
            fail_a   <= '0;
            fail_y   <= '0;
            fail_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A vector presented together with start is not counted.
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        vec_cnt  <= '0;
                        err_cnt  <= '0;
                        fail_vld <= 1'b0;
                        fail_a   <= '0;
                        fail_y   <= '0;
                        fail_idx <= '0;
                    end
                end
                RUN: begin
                    // start is ignored here; only valid vectors advance the run.
                    if (vld) begin
                        vec_cnt <= vec_cnt + 1'b1;
                        if (mismatch) begin
                            err_cnt <= sat_inc(err_cnt);
                            if (!fail_vld) begin
                                fail_vld <= 1'b1;
                                fail_a   <= a;
                                fail_y   <= y;
                                fail_idx <= vec_cnt;
                            end
                        end
                        if (vec_cnt == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt == '0) && !mismatch;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gnot16_checker.sv
// Bench for gnot16_checker: a behavioural run model checked every cycle
// against the main instance, plus hand-computed literal expectations and
// a small saturation instance.
module tb_gnot16_checker;

    localparam int W   = 16;
    localparam int NV  = 4;
    localparam int CW  = 8;
    localparam int SNV = 3;
    localparam int SCW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Main instance signals
    logic          start = 1'b0;
    logic          vld   = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  y     = '0;
    logic          busy, done, pass, fail_vld;
    logic [CW-1:0] vec_cnt, err_cnt, fail_idx;
    logic [W-1:0]  fail_a, fail_y;

    // Saturation instance signals
    logic           s_start = 1'b0;
    logic           s_vld   = 1'b0;
    logic [W-1:0]   s_a     = '0;
    logic [W-1:0]   s_y     = '0;
    logic           s_busy, s_done, s_pass, s_fail_vld;
    logic [SCW-1:0] s_vec_cnt, s_err_cnt, s_fail_idx;
    logic [W-1:0]   s_fail_a, s_fail_y;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    gnot16_checker #(.WIDTH(W), .N_VEC(NV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .y(y),
        .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt),
        .err_cnt(err_cnt), .fail_vld(fail_vld), .fail_a(fail_a),
        .fail_y(fail_y), .fail_idx(fail_idx)
    );

    gnot16_checker #(.WIDTH(W), .N_VEC(SNV), .CNT_W(SCW)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .vld(s_vld), .a(s_a), .y(s_y),
        .busy(s_busy), .done(s_done), .pass(s_pass), .vec_cnt(s_vec_cnt),
        .err_cnt(s_err_cnt), .fail_vld(s_fail_vld), .fail_a(s_fail_a),
        .fail_y(s_fail_y), .fail_idx(s_fail_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of a run: a list of accepted vectors summarised as
    // a count, an error total and the first failing pair.
    bit          m_running, m_finished, m_pass, m_fv;
    int          m_vc, m_errs, m_fidx;
    logic [W-1:0] m_fa, m_fy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_running = 0; m_finished = 0; m_pass = 0; m_fv = 0;
            m_vc = 0; m_errs = 0; m_fidx = 0; m_fa = '0; m_fy = '0;
        end else if (!m_running && start) begin
            m_running = 1; m_finished = 0; m_pass = 0; m_fv = 0;
            m_vc = 0; m_errs = 0; m_fidx = 0; m_fa = '0; m_fy = '0;
        end else if (m_running && vld) begin
            if (y !== ~a) begin
                m_errs++;
                if (!m_fv) begin
                    m_fv = 1; m_fa = a; m_fy = y; m_fidx = m_vc;
                end
            end
            m_vc++;
            if (m_vc == NV) begin
                m_running = 0; m_finished = 1; m_pass = (m_errs == 0);
            end
        end
    end

    // Compare the main instance against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            int e;
            e = (m_errs > 255) ? 255 : m_errs;
            chk("m_busy",     32'(busy),     32'(m_running));
            chk("m_done",     32'(done),     32'(m_finished));
            chk("m_pass",     32'(pass),     32'(m_pass));
            chk("m_vec_cnt",  32'(vec_cnt),  32'(m_vc));
            chk("m_err_cnt",  32'(err_cnt),  32'(e));
            chk("m_fail_vld", 32'(fail_vld), 32'(m_fv));
            chk("m_fail_a",   32'(fail_a),   32'(m_fa));
            chk("m_fail_y",   32'(fail_y),   32'(m_fy));
            chk("m_fail_idx", 32'(fail_idx), 32'(m_fidx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic apply(input logic [W-1:0] av, input logic [W-1:0] yv);
        vld = 1'b1; a = av; y = yv;
        tick();
        vld = 1'b0; a = '0; y = '0;
    endtask

    task automatic s_apply(input logic [W-1:0] av, input logic [W-1:0] yv);
        s_vld = 1'b1; s_a = av; s_y = yv;
        tick();
        s_vld = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_pass"},     32'(pass),     32'd0);
        chk({tag, "_vec_cnt"},  32'(vec_cnt),  32'd0);
        chk({tag, "_err_cnt"},  32'(err_cnt),  32'd0);
        chk({tag, "_fail_vld"}, 32'(fail_vld), 32'd0);
        chk({tag, "_fail_a"},   32'(fail_a),   32'd0);
        chk({tag, "_fail_y"},   32'(fail_y),   32'd0);
        chk({tag, "_fail_idx"}, 32'(fail_idx), 32'd0);
    endtask

    initial begin
        // Reset with no clock edge yet: outputs clear asynchronously.
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        chk("rst_async_s_err", 32'(s_err_cnt), 32'd0);
        tick();
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (5) tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // vld outside a run is ignored.
        apply(16'h1234, 16'h1234);
        chk("idle_vld_vec", 32'(vec_cnt), 32'd0);
        chk("idle_vld_busy", 32'(busy), 32'd0);

        // All-pass run.
        pulse_start();
        chk("run_busy", 32'(busy), 32'd1);
        apply(16'h3524, 16'hCADB);
        apply(16'h5E81, 16'hA17E);
        apply(16'h0000, 16'hFFFF);
        chk("pre_last_done", 32'(done), 32'd0);
        chk("pre_last_vec", 32'(vec_cnt), 32'd3);
        apply(16'hFFFF, 16'h0000);
        chk("ok_done", 32'(done), 32'd1);
        chk("ok_busy", 32'(busy), 32'd0);
        chk("ok_pass", 32'(pass), 32'd1);
        chk("ok_vec", 32'(vec_cnt), 32'd4);
        chk("ok_err", 32'(err_cnt), 32'd0);
        chk("ok_fv", 32'(fail_vld), 32'd0);

        // DONE holds results and ignores vld.
        apply(16'h0000, 16'h0000);
        chk("done_hold_vec", 32'(vec_cnt), 32'd4);
        chk("done_hold_err", 32'(err_cnt), 32'd0);

        // First-failure capture.
        pulse_start();
        apply(16'hD609, 16'hD609);
        apply(16'h1234, 16'hEDCB);
        apply(16'hFFFF, 16'h0001);
        apply(16'h00FF, 16'hFF00);
        chk("ff_done", 32'(done), 32'd1);
        chk("ff_err", 32'(err_cnt), 32'd2);
        chk("ff_idx", 32'(fail_idx), 32'd0);
        chk("ff_a", 32'(fail_a), 32'hD609);
        chk("ff_y", 32'(fail_y), 32'hD609);
        chk("ff_fv", 32'(fail_vld), 32'd1);
        chk("ff_pass", 32'(pass), 32'd0);

        // start with vld in DONE: restart clears, vector not counted.
        start = 1'b1; vld = 1'b1; a = 16'h0000; y = 16'h0000;
        tick();
        start = 1'b0; vld = 1'b0;
        chk("sv_busy", 32'(busy), 32'd1);
        chk("sv_vec", 32'(vec_cnt), 32'd0);
        chk("sv_err", 32'(err_cnt), 32'd0);
        chk("sv_fv", 32'(fail_vld), 32'd0);

        // Gaps with a start pulse mid-run: no restart, nothing counted.
        tick();
        pulse_start();
        tick();
        chk("gap_vec", 32'(vec_cnt), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        apply(16'hAAAA, 16'h5555);
        tick();
        apply(16'h0F0F, 16'hF0F0);
        pulse_start();
        chk("gap_midstart_vec", 32'(vec_cnt), 32'd2);
        apply(16'h8001, 16'h7FFE);
        apply(16'hC3C3, 16'h3C3C);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_pass", 32'(pass), 32'd1);
        chk("gap_fv", 32'(fail_vld), 32'd0);

        // Error only on the last vector must still fail the run.
        pulse_start();
        apply(16'h0001, 16'hFFFE);
        apply(16'h0002, 16'hFFFD);
        apply(16'h0004, 16'hFFFB);
        apply(16'h0008, 16'hFFF6);
        chk("last_bad_pass", 32'(pass), 32'd0);
        chk("last_bad_idx", 32'(fail_idx), 32'd3);
        chk("last_bad_y", 32'(fail_y), 32'hFFF6);

        // Saturation on the narrow instance.
        s_start = 1'b1; tick(); s_start = 1'b0;
        s_apply(16'h0000, 16'h0000);
        chk("sat_err1", 32'(s_err_cnt), 32'd1);
        s_apply(16'h0000, 16'h0000);
        chk("sat_err2", 32'(s_err_cnt), 32'd2);
        s_apply(16'h0000, 16'h0000);
        chk("sat_err3", 32'(s_err_cnt), 32'd3);
        chk("sat_vec", 32'(s_vec_cnt), 32'd3);
        chk("sat_done", 32'(s_done), 32'd1);
        chk("sat_pass", 32'(s_pass), 32'd0);
        s_apply(16'h0000, 16'h0000);
        chk("sat_hold", 32'(s_err_cnt), 32'd3);

        // Reset mid-run aborts to reset values.
        pulse_start();
        apply(16'h1111, 16'h1111);
        chk("mid_vec", 32'(vec_cnt), 32'd1);
        chk("mid_fv", 32'(fail_vld), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
